// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core: opcode values, the bubble instruction
// and the fetch-stage state encoding.
package cpu_pkg;

  localparam logic [5:0]  OP_RTYPE  = 6'b000000;
  localparam logic [5:0]  OP_LW     = 6'b100011;
  localparam logic [5:0]  OP_SW     = 6'b101011;
  localparam logic [5:0]  OP_BEQ    = 6'b000100;
  localparam logic [5:0]  OP_ADDI   = 6'b001000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DISCARD,
    S_HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush clears to the NOP bubble, load captures a new
// instruction, otherwise the contents are held.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic [31:0]       instr_d,
  input  logic [ADDR_W-1:0] pc4_d,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc4,
  output logic              valid
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      instr <= NOP_INSTR;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_d;
      pc4   <= pc4_d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, stall and branch redirect.
// Optional FETCH_BUBBLE_CNT_EN adds a saturating bubble_cnt output.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc4,
  output logic              if_id_valid,
`ifdef FETCH_BUBBLE_CNT_EN
  output logic [31:0]       bubble_cnt,
`endif
  output logic [5:0]        opcode
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  fetch_state_t      state, state_d;
  logic [ADDR_W-1:0] pc, pc_d, req_addr, req_addr_d, pc_plus4, target;
  logic [31:0]       hold_instr;
  logic [ADDR_W-1:0] hold_pc4;
  logic              buf_load, ifid_load, ifid_flush;
  logic [31:0]       ifid_instr_d;
  logic [ADDR_W-1:0] ifid_pc4_d;

  assign pc_plus4  = pc + ADDR_W'(4);
  assign target    = {branch_target[ADDR_W-1:2], 2'b00};
  assign imem_addr = req_addr;
  assign opcode    = if_id_instr[31:26];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:    state_d = S_FETCH;
      S_FETCH: begin
        if (imem_valid) begin
          if (!branch_taken && stall) state_d = S_HOLD;
        end else if (branch_taken) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: if (imem_valid) state_d = S_FETCH;
      S_HOLD:    if (branch_taken || !stall) state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req     = (state == S_FETCH) || (state == S_DISCARD);
    pc_d         = pc;
    req_addr_d   = req_addr;
    buf_load     = 1'b0;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_instr_d = imem_rdata;
    ifid_pc4_d   = pc_plus4;
    case (state)
      S_IDLE: req_addr_d = pc;
      S_FETCH: begin
        if (imem_valid) begin
          if (branch_taken) begin
            pc_d       = target;
            req_addr_d = target;
            ifid_flush = 1'b1;
          end else if (stall) begin
            buf_load = 1'b1;
            pc_d     = pc_plus4;
          end else begin
            ifid_load  = 1'b1;
            pc_d       = pc_plus4;
            req_addr_d = pc_plus4;
          end
        end else if (branch_taken) begin
          pc_d       = target;
          ifid_flush = 1'b1;
        end else if (!stall) begin
          ifid_flush = 1'b1;
        end
      end
      S_DISCARD: begin
        // A redirect here replaces the pending target; the stale response is still dropped.
        if (branch_taken) begin
          pc_d       = target;
          ifid_flush = 1'b1;
        end else if (!stall) begin
          ifid_flush = 1'b1;
        end
        if (imem_valid) req_addr_d = pc_d;
      end
      S_HOLD: begin
        if (branch_taken) begin
          pc_d       = target;
          req_addr_d = target;
          ifid_flush = 1'b1;
        end else if (!stall) begin
          ifid_load    = 1'b1;
          ifid_instr_d = hold_instr;
          ifid_pc4_d   = hold_pc4;
          req_addr_d   = pc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RST_PC;
      req_addr   <= RST_PC;
      hold_instr <= '0;
      hold_pc4   <= '0;
    end else begin
      pc       <= pc_d;
      req_addr <= req_addr_d;
      if (buf_load) begin
        hold_instr <= imem_rdata;
        hold_pc4   <= pc_plus4;
      end
    end
  end

  if_id_reg #(.ADDR_W(ADDR_W)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load    (ifid_load),
    .flush   (ifid_flush),
    .instr_d (ifid_instr_d),
    .pc4_d   (ifid_pc4_d),
    .instr   (if_id_instr),
    .pc4     (if_id_pc4),
    .valid   (if_id_valid)
  );

`ifdef FETCH_BUBBLE_CNT_EN
  logic valid_nxt;
  assign valid_nxt = ifid_flush ? 1'b0 : (ifid_load ? 1'b1 : if_id_valid);

  always_ff @(posedge clk) begin
    if (rst)                              bubble_cnt <= '0;
    else if (!valid_nxt && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; a second instance covers PC wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, mem_en;
  logic [31:0] branch_target;
  logic        imem_req, imem_valid, if_id_valid;
  logic [31:0] imem_addr, imem_rdata, if_id_instr, if_id_pc4;
  logic [5:0]  opcode;
  logic        imem_req2, imem_valid2, if_id_valid2;
  logic [31:0] imem_addr2, imem_rdata2, if_id_instr2, if_id_pc42;
  logic [5:0]  opcode2;
`ifdef FETCH_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt, bubble_cnt2;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
`ifdef FETCH_BUBBLE_CNT_EN
    .bubble_cnt(bubble_cnt),
`endif
    .opcode(opcode)
  );

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .imem_valid(imem_valid2), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .if_id_instr(if_id_instr2), .if_id_pc4(if_id_pc42), .if_id_valid(if_id_valid2),
`ifdef FETCH_BUBBLE_CNT_EN
    .bubble_cnt(bubble_cnt2),
`endif
    .opcode(opcode2)
  );

  // Memory: responds in the request cycle whenever mem_en is high.
  always_comb begin
    imem_valid  = imem_req && mem_en;
    imem_rdata  = imem_addr | 32'h2000_0000;
    imem_valid2 = imem_req2 && mem_en;
    imem_rdata2 = imem_addr2 | 32'h2000_0000;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, then one edge so both instances sit in S_FETCH with the first request out.
  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; mem_en = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; mem_en = 1'b1;
    step(); step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", imem_addr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", if_id_valid); end
    checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h expected 0", if_id_instr); end
    checks++; if (if_id_pc4 !== 32'h0) begin errors++; $display("FAIL rst_pc4: got %h expected 0", if_id_pc4); end
    rst = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL idle_to_fetch: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (imem_addr !== 32'(4 * k)) begin errors++; $display("FAIL zw_addr%0d: got %h expected %h", k, imem_addr, 32'(4 * k)); end
      checks++; if (if_id_pc4 !== 32'(4 * k) || if_id_valid !== 1'b1) begin errors++; $display("FAIL zw_pc4_%0d: got %h/%b expected %h/1", k, if_id_pc4, if_id_valid, 32'(4 * k)); end
      checks++; if (if_id_instr !== (32'h2000_0000 | 32'(4 * (k - 1)))) begin errors++; $display("FAIL zw_instr%0d: got %h expected %h", k, if_id_instr, 32'h2000_0000 | 32'(4 * (k - 1))); end
    end
    checks++; if (opcode !== 6'b001000) begin errors++; $display("FAIL zw_opcode: got %b expected 001000", opcode); end
  endtask

  task automatic test_stall();
    do_reset();
    step(); step();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req%0d: got %b expected 0", k, imem_req); end
      checks++; if (if_id_instr !== 32'h2000_0004 || if_id_pc4 !== 32'h8) begin errors++; $display("FAIL hold_ifid%0d: got %h/%h expected 20000004/8", k, if_id_instr, if_id_pc4); end
    end
    stall = 1'b0;
    step();
    checks++; if (if_id_instr !== 32'h2000_0008 || if_id_pc4 !== 32'hC) begin errors++; $display("FAIL release_ifid: got %h/%h expected 20000008/c", if_id_instr, if_id_pc4); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL release_addr: got %b/%h expected 1/c", imem_req, imem_addr); end
    step();
    checks++; if (if_id_instr !== 32'h2000_000C || if_id_pc4 !== 32'h10) begin errors++; $display("FAIL after_release: got %h/%h expected 2000000c/10", if_id_instr, if_id_pc4); end
  endtask

  task automatic test_branch_valid();
    do_reset();
    step();
    branch_taken = 1'b1; branch_target = 32'h0000_0043;
    step();
    branch_taken = 1'b0;
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || opcode !== 6'b0) begin errors++; $display("FAIL br_flush: got %b/%h/%b expected 0/0/000000", if_id_valid, if_id_instr, opcode); end
    checks++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin errors++; $display("FAIL br_addr: got %h/%b expected 40/1", imem_addr, imem_req); end
    step();
    checks++; if (if_id_instr !== 32'h2000_0040 || if_id_pc4 !== 32'h44) begin errors++; $display("FAIL br_target_instr: got %h/%h expected 20000040/44", if_id_instr, if_id_pc4); end
  endtask

  task automatic test_branch_wait();
    do_reset();
    step(); step(); step(); step();
    mem_en = 1'b0;
    step();
    checks++; if (if_id_valid !== 1'b0 || imem_addr !== 32'h10) begin errors++; $display("FAIL wait_bubble: got %b/%h expected 0/10", if_id_valid, imem_addr); end
    branch_taken = 1'b1; branch_target = 32'h80;
    step();
    branch_taken = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL discard_req: got %b/%h expected 1/10", imem_req, imem_addr); end
    step();
    mem_en = 1'b1;
    step();
    checks++; if (imem_addr !== 32'h80 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin errors++; $display("FAIL discard_drop: got %h/%b/%h expected 80/0/0", imem_addr, if_id_valid, if_id_instr); end
    step();
    checks++; if (if_id_instr !== 32'h2000_0080 || if_id_pc4 !== 32'h84) begin errors++; $display("FAIL discard_next: got %h/%h expected 20000080/84", if_id_instr, if_id_pc4); end
  endtask

  task automatic test_branch_stall();
    do_reset();
    step(); step();
    branch_taken = 1'b1; stall = 1'b1; branch_target = 32'h100;
    step();
    branch_taken = 1'b0; stall = 1'b0;
    checks++; if (if_id_valid !== 1'b0 || imem_addr !== 32'h100 || imem_req !== 1'b1) begin errors++; $display("FAIL brst_flush: got %b/%h/%b expected 0/100/1", if_id_valid, imem_addr, imem_req); end
    step();
    checks++; if (if_id_instr !== 32'h2000_0100 || if_id_pc4 !== 32'h104) begin errors++; $display("FAIL brst_next: got %h/%h expected 20000100/104", if_id_instr, if_id_pc4); end
    do_reset();
    step();
    stall = 1'b1;
    step();
    branch_taken = 1'b1; branch_target = 32'h200;
    step();
    branch_taken = 1'b0; stall = 1'b0;
    checks++; if (if_id_valid !== 1'b0 || imem_addr !== 32'h200 || imem_req !== 1'b1) begin errors++; $display("FAIL hold_branch: got %b/%h/%b expected 0/200/1", if_id_valid, imem_addr, imem_req); end
  endtask

  task automatic test_wrap();
    do_reset();
    checks++; if (imem_addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0: got %h expected fffffffc", imem_addr2); end
    step();
    checks++; if (imem_addr2 !== 32'h0) begin errors++; $display("FAIL wrap_addr1: got %h expected 0", imem_addr2); end
    checks++; if (if_id_pc42 !== 32'h0 || if_id_instr2 !== 32'hFFFF_FFFC || if_id_valid2 !== 1'b1) begin errors++; $display("FAIL wrap_ifid: got %h/%h/%b expected 0/fffffffc/1", if_id_pc42, if_id_instr2, if_id_valid2); end
    step();
    checks++; if (if_id_pc42 !== 32'h4 || if_id_instr2 !== 32'h2000_0000) begin errors++; $display("FAIL wrap_next: got %h/%h expected 4/20000000", if_id_pc42, if_id_instr2); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_branch_valid();
    test_branch_wait();
    test_branch_stall();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the MIPS core; sits directly upstream of the control unit.
- Drives the PC and requests instructions from instruction memory over a req/valid handshake.
- Registers the fetched instruction and PC+4 for decode, and exposes the opcode field to the control unit.
- Supports hazard stalls and branch redirect/flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- ADDR_W, 32, PC/address width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request; held high until accepted.
- imem_addr  output  ADDR_W  fetch address; stable while imem_req=1.
- imem_rdata  input  32  instruction word; sampled when imem_valid=1.
- imem_valid  input  1  response strobe; legal only while imem_req=1; may occur in the same cycle as req (zero wait).
- stall  input  1  hazard unit holds IF/ID and PC.
- branch_taken  input  1  redirect from branch resolution (beq).
- branch_target  input  ADDR_W  redirect address; bits [1:0] are forced to 0.
- if_id_instr  output  32  registered instruction; 32'h0 whenever if_id_valid=0.
- if_id_pc4  output  ADDR_W  registered PC+4 of if_id_instr.
- if_id_valid  output  1  IF/ID holds a real instruction.
- opcode  output  6  combinational if_id_instr[31:26]; feeds control unit OpCode.

Behaviour:
- Reset values: pc=RESET_PC, req_addr=RESET_PC, imem_req=0, if_id_instr=0, if_id_pc4=0, if_id_valid=0, hold buffer=0, state=S_IDLE. Reset mid-transaction discards any outstanding request; memory must tolerate req dropping.
- Bubble encoding: any cleared IF/ID holds 32'h0 (sll $0,$0,0, opcode 000000), so the control unit never sees an undecoded opcode.
- imem_req=1 in S_FETCH and S_DISCARD, else 0. imem_addr=req_addr (register). On each new request, req_addr<=pc.
- S_IDLE (one cycle after reset): -> S_FETCH; req_addr<=pc.
- S_FETCH:
  - imem_valid=1 & branch_taken: drop data, pc<=target, req_addr<=target, IF/ID flushed; stay.
  - imem_valid=1 & stall: data -> hold buffer (instr, pc+4); pc<=pc+4; IF/ID unchanged; -> S_HOLD.
  - imem_valid=1 & !stall: IF/ID<=(rdata, pc+4, valid=1); pc<=pc+4; req_addr<=pc+4; stay. Zero-wait memory gives 1 instr/cycle.
  - imem_valid=0 & branch_taken: pc<=target; IF/ID flushed; -> S_DISCARD (req_addr unchanged, request still outstanding).
  - imem_valid=0 & !stall: IF/ID becomes bubble.
  - imem_valid=0 & stall: IF/ID held.
- S_DISCARD: imem_valid=1: drop data, req_addr<=pc, -> S_FETCH. branch_taken while here: pc<=new target, IF/ID flushed.
- S_HOLD:
  - branch_taken: drop buffer, pc<=target, req_addr<=target, flush, -> S_FETCH.
  - Otherwise !stall: IF/ID<=buffer, req_addr<=pc, -> S_FETCH.
  - Otherwise: stay.
- Priority: rst > branch_taken (flush) > stall > normal. Simultaneous branch_taken and stall: flush wins; IF/ID becomes bubble.
- PC arithmetic is modulo 2^ADDR_W; 32'hFFFF_FFFC+4 wraps to 0 without error.
- Latency: instruction visible on if_id_instr on the edge after imem_valid (1 cycle).

Optional Feature:
- FETCH_BUBBLE_CNT_EN: adds output port bubble_cnt (32 bits), reset to 0, incremented each cycle that if_id_valid is 0 after the clock edge; saturates at 32'hFFFF_FFFF.
- Without the macro: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg: opcode localparams (OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_ADDI=6'b001000), NOP_INSTR=32'h0, fetch state encoding (S_IDLE, S_FETCH, S_DISCARD, S_HOLD).
- Natural sub-module if_id_reg: the IF/ID register with load/hold/flush controls. The PC and FSM stay in fetch_stage.

Test Plan:
- Reset then zero-wait memory returning rdata=addr|32'h2000_0000 → imem_addr 0,4,8,... consecutive cycles; if_id_pc4 4,8,12; if_id_valid=1 from second cycle after rst low.
- stall=1 for 3 cycles while instr at addr 8 is returned → IF/ID holds addr-4 instr; imem_req=0 in S_HOLD; on release addr-8 instr appears once, next fetch is 0xC; no instruction is lost or duplicated.
- branch_taken with target 0x40 while imem_valid=1 → next IF/ID=0/valid=0, opcode=000000; following imem_addr=0x40.
- branch_taken while memory 3-cycle wait outstanding at 0x10 → S_DISCARD; 0x10 response dropped; next request at target; no 0x10 instr in IF/ID.
- branch_taken & stall same cycle → flush wins; pc=target; if_id_valid=0.
- RESET_PC=32'hFFFF_FFFC, zero-wait → addresses FFFF_FFFC then 0000_0000; if_id_pc4 of the first instr = 0.
